// File: rtl/axi4_ram_pkg.sv
// axi4_ram_pkg: shared widths, FSM state encoding and response codes for
// the AXI4-Lite RAM slave and its storage array.
package axi4_ram_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    // Held for when a RESP channel is added; every transfer today is OKAY.
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_WDATA_ENC = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
    localparam logic [2:0] ST_RRESP_ENC = 3'd3;
    localparam logic [2:0] ST_BRESP_ENC = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE_ENC,
        WDATA = ST_WDATA_ENC,
        WAIT  = ST_WAIT_ENC,
        RRESP = ST_RRESP_ENC,
        BRESP = ST_BRESP_ENC
    } state_t;

endpackage

// File: rtl/ram_sp_bytewe.sv
// ram_sp_bytewe: single-port 32-bit word array with per-byte write enables
// and a registered read port. The array itself is never reset; only the
// read register is.
module ram_sp_bytewe
    import axi4_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AXI_STRB_W-1:0]          we,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [AXI_DATA_W-1:0]          wdata,
    output logic [AXI_DATA_W-1:0]          rdata
);

    logic [AXI_DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write: only lanes with their enable set are touched.
    always_ff @(posedge clk) begin
        for (int i = 0; i < AXI_STRB_W; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read register captures the addressed word and holds it until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// axi4_lite_ram_slave: AXI4-Lite slave over a byte-writable RAM, one
// transaction outstanding at a time, writes win a simultaneous AR/AW.
// Optional build macro AXI_RAM_WAIT_EN inserts WAIT_CYCLES wait states
// between the commit and the response.
module axi4_lite_ram_slave
    import axi4_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t                state, state_n;
    logic [IDX_W-1:0]      addr_q;
    logic                  addr_ld;
    logic [IDX_W-1:0]      ram_idx;
    logic [AXI_STRB_W-1:0] ram_we;
    logic                  ram_re;
    logic [AXI_DATA_W-1:0] ram_rdata;

    // Address bits outside the word index are don't-care (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_araddr[AXI_ADDR_W-1:IDX_W+2], s_axi_araddr[1:0],
                                s_axi_awaddr[AXI_ADDR_W-1:IDX_W+2], s_axi_awaddr[1:0]};

`ifdef AXI_RAM_WAIT_EN
    logic [15:0] wait_cnt;
    logic        resp_rd;

    function automatic state_t commit_next(input logic is_rd);
        if (WAIT_CYCLES > 0) return WAIT;
        return is_rd ? RRESP : BRESP;
    endfunction

    // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Remembers whether the transaction parked in WAIT owes an R or a B response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rd <= 1'b0;
        end else if (state != WAIT) begin
            resp_rd <= ram_re;
        end
    end
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;

    function automatic state_t commit_next(input logic is_rd);
        return is_rd ? RRESP : BRESP;
    endfunction
`endif

    // State register and the write address latched when W lags AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_n;
            if (addr_ld) begin
                addr_q <= s_axi_awaddr[IDX_W+1:2];
            end
        end
    end

    // Next-state, handshake readies and RAM strobes; all quiet while in reset.
    always_comb begin
        state_n       = state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        addr_ld       = 1'b0;
        ram_we        = '0;
        ram_re        = 1'b0;
        ram_idx       = addr_q;
        case (state)
            IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = s_axi_awvalid;
                s_axi_arready = !s_axi_awvalid;
                if (s_axi_awvalid && s_axi_wvalid) begin
                    ram_we  = s_axi_wstrb;
                    ram_idx = s_axi_awaddr[IDX_W+1:2];
                    state_n = commit_next(1'b0);
                end else if (s_axi_awvalid) begin
                    addr_ld = 1'b1;
                    state_n = WDATA;
                end else if (s_axi_arvalid) begin
                    ram_re  = 1'b1;
                    ram_idx = s_axi_araddr[IDX_W+1:2];
                    state_n = commit_next(1'b1);
                end
            end
            WDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    ram_we  = s_axi_wstrb;
                    state_n = commit_next(1'b0);
                end
            end
`ifdef AXI_RAM_WAIT_EN
            WAIT: begin
                if (wait_cnt == 16'(WAIT_CYCLES - 1)) begin
                    state_n = resp_rd ? RRESP : BRESP;
                end
            end
`endif
            RRESP: begin
                if (s_axi_rready) state_n = IDLE;
            end
            BRESP: begin
                if (s_axi_bready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            s_axi_awready = 1'b0;
            s_axi_wready  = 1'b0;
            s_axi_arready = 1'b0;
            addr_ld       = 1'b0;
            ram_we        = '0;
            ram_re        = 1'b0;
        end
    end

    assign s_axi_rvalid = (state == RRESP);
    assign s_axi_bvalid = (state == BRESP);
    assign s_axi_rdata  = s_axi_rvalid ? ram_rdata : '0;

    ram_sp_bytewe #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (s_axi_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// tb_axi4_lite_ram_slave: directed and randomized AXI4-Lite traffic against
// a word-array reference model of the RAM slave.
module tb_axi4_lite_ram_slave;

    localparam int DEPTH    = 4096;
    localparam int WAIT_CYC = 2;
`ifdef AXI_RAM_WAIT_EN
    localparam int LAT = WAIT_CYC;
`else
    localparam int LAT = 0;
`endif
    localparam int REGION = 64;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [DEPTH];

    axi4_lite_ram_slave #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAIT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int k;
        k = widx(addr);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) mem_m[k][i*8 +: 8] = data[i*8 +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr(input int idx);
        return ($urandom & 32'hFFFF_C003) | (32'(idx) << 2);
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int gap, input int bdly);
        @(posedge clk); #1;
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = (gap == 0);
        @(negedge clk);
        chk("aw_awready", 32'(awready), 32'd1);
        chk("aw_wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        awaddr  = $urandom;
        if (gap > 0) begin
            repeat (gap - 1) begin
                @(negedge clk);
                chk("wd_awready", 32'(awready), 32'd0);
                chk("wd_wready", 32'(wready), 32'd1);
                chk("wd_bvalid", 32'(bvalid), 32'd0);
                @(posedge clk); #1;
            end
            wvalid = 1'b1;
            @(negedge clk);
            chk("wd_wready_hs", 32'(wready), 32'd1);
            chk("wd_awready_hs", 32'(awready), 32'd0);
            @(posedge clk); #1;
            wvalid = 1'b0;
        end
        model_write(addr, data, strb);
        repeat (LAT) begin
            @(negedge clk);
            chk("b_wait", 32'(bvalid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b_rise", 32'(bvalid), 32'd1);
        chk("b_awready", 32'(awready), 32'd0);
        repeat (bdly) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("b_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("b_done", 32'(bvalid), 32'd0);
        chk("b_idle_awready", 32'(awready), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int rdly);
        @(posedge clk); #1;
        araddr  = addr;
        arvalid = 1'b1;
        @(negedge clk);
        chk("ar_arready", 32'(arready), 32'd1);
        chk("ar_rvalid", 32'(rvalid), 32'd0);
        chk("ar_rdata0", rdata, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        repeat (LAT) begin
            @(negedge clk);
            chk("r_wait", 32'(rvalid), 32'd0);
            chk("r_wait_rdata0", rdata, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("r_rise", 32'(rvalid), 32'd1);
        chk("r_data", rdata, exp);
        repeat (rdly) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("r_hold_valid", 32'(rvalid), 32'd1);
            chk("r_hold_data", rdata, exp);
            chk("r_hold_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("r_done", 32'(rvalid), 32'd0);
        chk("r_done_rdata0", rdata, 32'd0);
        chk("r_idle_arready", 32'(arready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", 32'(awready), 32'd1);
        chk("idle_arready", 32'(arready), 32'd1);

        // Give every word of the exercised region a known value.
        for (int i = 0; i < REGION; i++) axi_write(32'(i) << 2, $urandom, 4'hF, 0, 0);

        // Same-cycle AW+W then readback.
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(32'h10, 32'hDEADBEEF, 0);

        // AW first, W three cycles later with partial strobes.
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_write(32'h20, 32'h12345678, 4'h5, 3, 1);
        axi_read(32'h20, 32'hFF34FF78, 0);

        // W without AW is not accepted.
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = 32'h0BAD0BAD; wstrb = 4'hF;
        @(negedge clk);
        chk("w_before_aw_wready", 32'(wready), 32'd0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        axi_read(32'h10, 32'hDEADBEEF, 0);

        // Simultaneous AR and AW: write first, read after B.
        d = $urandom;
        @(posedge clk); #1;
        araddr = 32'h40; arvalid = 1'b1;
        awaddr = 32'h44; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        chk("both_arready", 32'(arready), 32'd0);
        chk("both_awready", 32'(awready), 32'd1);
        chk("both_wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(32'h44, d, 4'hF);
        repeat (LAT) begin
            @(negedge clk);
            chk("both_wait_arready", 32'(arready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("both_bvalid", 32'(bvalid), 32'd1);
        chk("both_b_arready", 32'(arready), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("both_ar_after_b", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (LAT) begin
            @(negedge clk);
            chk("both_r_wait", 32'(rvalid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("both_rvalid", 32'(rvalid), 32'd1);
        chk("both_rdata", rdata, mem_m[16]);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        axi_read(32'h44, d, 0);

        // Back-pressured read.
        axi_read(32'h0, mem_m[0], 5);

        // Out-of-range address wraps onto word 0.
        axi_write(32'h4000, 32'hA5A5A5A5, 4'hF, 0, 0);
        axi_read(32'h0, 32'hA5A5A5A5, 0);

        // wstrb=0 leaves the word untouched but still completes.
        axi_write(32'h0, 32'h11111111, 4'h0, 0, 0);
        axi_read(32'h0, 32'hA5A5A5A5, 0);

        // Reset during BRESP: response dropped, write kept.
        d = $urandom;
        @(posedge clk); #1;
        awaddr = 32'h80; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(32'h80, d, 4'hF);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_bvalid_pre", 32'(bvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_bvalid", 32'(bvalid), 32'd0);
        chk("rst_mid_awready", 32'(awready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_bvalid", 32'(bvalid), 32'd0);
        chk("post_rst_awready", 32'(awready), 32'd1);
        axi_read(32'h80, d, 0);

        // Randomized traffic over the region with random alias bits.
        for (int n = 0; n < 200; n++) begin
            int idx;
            idx = int'($urandom_range(REGION - 1, 0));
            if ($urandom_range(1, 0) == 1) begin
                axi_write(rand_addr(idx), $urandom, 4'($urandom), int'($urandom_range(3, 0)),
                          int'($urandom_range(3, 0)));
            end else begin
                axi_read(rand_addr(idx), mem_m[idx], int'($urandom_range(3, 0)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_ram_slave.md
AXI4_LITE_RAM_SLAVE -- requirements
Module: axi4_lite_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words; power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra response wait states; used only when AXI_RAM_WAIT_EN is defined.
REQ-003 SHALL have one clock and an asynchronous, active-high reset. The ports are clk (in, 1) and rst (in, 1).
REQ-004 SHALL expose s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1.
REQ-005 SHALL expose s_axi_rdata out 32, s_axi_rvalid out 1, s_axi_rready in 1.
REQ-006 SHALL expose s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1.
REQ-007 SHALL expose s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1.
REQ-008 SHALL expose s_axi_bvalid out 1, s_axi_bready in 1. There are no RESP, ID, LEN or LAST signals; every transfer is single-beat OKAY.

Function
REQ-009 SHALL implement states IDLE, WDATA, WAIT, RRESP and BRESP, with one transaction outstanding at a time.
REQ-010 In IDLE: awready=1, wready=awvalid, and arready=!awvalid. Write wins a simultaneous AR+AW. In every other state, arready=awready=0.
REQ-011 IDLE, AW and W handshake in the same cycle: write memory at that edge, then go to BRESP (or WAIT).
REQ-012 IDLE, AW handshake without W: latch the address and go to WDATA. In WDATA, wready=1. The W handshake writes memory, then goes to BRESP (or WAIT).
REQ-013 W presented before AW SHALL NOT be accepted (wready=0 while awvalid=0 in IDLE).
REQ-014 IDLE, AR handshake: read the word at that edge into the rdata register, then go to RRESP (or WAIT).
REQ-015 Word index = addr[log2(DEPTH_WORDS)+1:2]. addr[1:0] and upper bits are ignored, so out-of-range addresses wrap.
REQ-016 A write SHALL update byte lane i only where wstrb[i]=1. wstrb=0 is a legal no-op write that still returns B.
REQ-017 In RRESP, rvalid=1 and rdata is held stable until rready. On the rvalid&rready edge, return to IDLE.
REQ-018 In BRESP, bvalid=1 until bready. On the bvalid&bready edge, return to IDLE.
REQ-019 Latency without wait states: address handshake at edge N gives rvalid/bvalid high in cycle N+1. A new address can be accepted the cycle after the response handshake.
REQ-020 A read accepted after a write's B handshake SHALL return the written data. No stale-data hazard is allowed.
REQ-021 rdata SHALL be 0 whenever rvalid=0.

Reset
REQ-022 While rst=1: state=IDLE, all ready/valid outputs 0, rdata=0, latched address and wait counter cleared.
REQ-023 Memory contents SHALL NOT be cleared by reset. A write whose W handshake edge preceded reset stays committed.
REQ-024 Reset mid-transaction SHALL drop the pending response. After release, the block accepts new requests from IDLE.

Configuration
REQ-025 Macro AXI_RAM_WAIT_EN defined: after the address/data commit, the FSM spends WAIT_CYCLES cycles in WAIT (counter), then enters RRESP/BRESP. Response rises in cycle N+1+WAIT_CYCLES. WAIT_CYCLES=0 behaves as undefined.
REQ-026 Macro undefined: the WAIT state and counter are absent, and latency is per REQ-019.

Structure
REQ-027 Package axi4_ram_pkg SHALL hold the state encoding localparams, AXI data/address/strobe widths, and the OKAY constant for future RESP use.
REQ-028 Sub-module ram_sp_bytewe SHALL hold the single-port 32-bit array with 4 byte write enables and a synchronous read register. The FSM lives in axi4_lite_ram_slave.

Verification
REQ-029 Write aw=0x10, w=0xDEADBEEF, wstrb=0xF in the same cycle, bready=1, then read 0x10 -> bvalid at N+1, rdata=0xDEADBEEF at the next read's N+1.
REQ-030 AW=0x20 at cycle 0, W=0x12345678 with wstrb=0x5 at cycle 3, over prior 0xFFFFFFFF -> awready only in cycle 0, stays in WDATA, readback 0xFF34FF78.
REQ-031 arvalid and awvalid both high in IDLE (ar=0x40, aw=0x44) -> write accepted first (arready=0 that cycle), read accepted after the B handshake.
REQ-032 Read 0x0 with rready held low 5 cycles -> rvalid and rdata stable for 5 cycles, then one handshake, then back in IDLE.
REQ-033 DEPTH_WORDS=4096, write 0x4000 with 0xA5A5A5A5 -> read 0x0 returns 0xA5A5A5A5 (wrap).
REQ-034 Assert rst during BRESP -> bvalid=0 immediately; after release, the written data reads back. With AXI_RAM_WAIT_EN and WAIT_CYCLES=2, rvalid rises at N+3.
